// File: rtl/ofdm_cp_serializer_pkg.sv
// rtl/ofdm_cp_serializer_pkg.sv - shared OFDM constants and cyclic-prefix FSM states
package ofdm_cp_serializer_pkg;

  localparam int WORD_SIZE_DEF = 16;
  localparam int N_POINTS_DEF  = 32;
  localparam int CP_LEN_DEF    = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CP   = 2'd1,
    ST_BODY = 2'd2
  } cp_state_t;

  function automatic int idx_width(input int n_points);
    return $clog2(n_points);
  endfunction

endpackage

// File: rtl/ofdm_frame_buffer.sv
// rtl/ofdm_frame_buffer.sv - one OFDM symbol of complex samples with a full flag
module ofdm_frame_buffer
  import ofdm_cp_serializer_pkg::*;
#(
  parameter int WORD_SIZE = WORD_SIZE_DEF,
  parameter int N_POINTS  = N_POINTS_DEF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          load,
  input  logic                          clear,
  input  logic [N_POINTS*WORD_SIZE-1:0] load_re,
  input  logic [N_POINTS*WORD_SIZE-1:0] load_im,
  output logic [N_POINTS*WORD_SIZE-1:0] data_re,
  output logic [N_POINTS*WORD_SIZE-1:0] data_im,
  output logic                          full
);

  // A load wins over a clear so a buffer can be emptied and refilled on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_re <= '0;
      data_im <= '0;
      full    <= 1'b0;
    end else if (load) begin
      data_re <= load_re;
      data_im <= load_im;
      full    <= 1'b1;
    end else if (clear) begin
      full    <= 1'b0;
    end
  end

endmodule

// File: rtl/ofdm_cp_serializer.sv
// rtl/ofdm_cp_serializer.sv - captures parallel IFFT frames and streams them with a cyclic prefix
module ofdm_cp_serializer
  import ofdm_cp_serializer_pkg::*;
#(
  parameter int WORD_SIZE = WORD_SIZE_DEF,
  parameter int N_POINTS  = N_POINTS_DEF,
  parameter int CP_LEN    = CP_LEN_DEF
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [N_POINTS*WORD_SIZE-1:0] i_frame_re,
  input  logic [N_POINTS*WORD_SIZE-1:0] i_frame_im,
  input  logic                          i_frame_valid,
  output logic [WORD_SIZE-1:0]          o_sample_re,
  output logic [WORD_SIZE-1:0]          o_sample_im,
  output logic                          o_valid,
  input  logic                          i_ready,
  output logic                          o_sof,
  output logic                          o_eof,
  output logic                          o_overflow,
  output logic                          o_busy
);

  localparam int                FW       = N_POINTS * WORD_SIZE;
  localparam int                IDX_W    = idx_width(N_POINTS);
  localparam logic [IDX_W-1:0]  CP_START = IDX_W'(N_POINTS - CP_LEN);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N_POINTS - 1);

  cp_state_t        state, state_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic             overflow;
  logic             hs, body_done, act_free;
  logic             act_full, pend_full;
  logic             act_load, act_clear, pend_load, pend_clear, drop;
  logic [FW-1:0]    act_re, act_im, pend_re, pend_im, act_src_re, act_src_im;

  assign hs        = (state != ST_IDLE) & i_ready;
  assign body_done = (state == ST_BODY) & (idx == LAST_IDX) & hs;
  assign act_free  = ~act_full | body_done;

  // Buffer steering: pending always drains into active before a newer frame can.
  always_comb begin
    act_load   = 1'b0;
    act_clear  = 1'b0;
    pend_load  = 1'b0;
    pend_clear = 1'b0;
    drop       = 1'b0;
    act_src_re = i_frame_re;
    act_src_im = i_frame_im;
    if (i_frame_valid) begin
      if (act_free && pend_full) begin
        act_load   = 1'b1;
        act_src_re = pend_re;
        act_src_im = pend_im;
        pend_load  = 1'b1;
      end else if (act_free) begin
        act_load = 1'b1;
      end else if (!pend_full) begin
        pend_load = 1'b1;
      end else begin
        drop = 1'b1;
      end
    end else if (body_done) begin
      if (pend_full) begin
        act_load   = 1'b1;
        act_src_re = pend_re;
        act_src_im = pend_im;
        pend_clear = 1'b1;
      end else begin
        act_clear = 1'b1;
      end
    end
  end

  ofdm_frame_buffer #(.WORD_SIZE(WORD_SIZE), .N_POINTS(N_POINTS)) u_active (
    .clk(i_clk), .rst_n(i_rst), .load(act_load), .clear(act_clear),
    .load_re(act_src_re), .load_im(act_src_im),
    .data_re(act_re), .data_im(act_im), .full(act_full)
  );

  ofdm_frame_buffer #(.WORD_SIZE(WORD_SIZE), .N_POINTS(N_POINTS)) u_pending (
    .clk(i_clk), .rst_n(i_rst), .load(pend_load), .clear(pend_clear),
    .load_re(i_frame_re), .load_im(i_frame_im),
    .data_re(pend_re), .data_im(pend_im), .full(pend_full)
  );

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state    <= ST_IDLE;
      idx      <= '0;
      overflow <= 1'b0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      if (drop) overflow <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    case (state)
      ST_IDLE: begin
        if (act_load) begin
          state_nxt = ST_CP;
          idx_nxt   = CP_START;
        end
      end
      ST_CP: begin
        if (hs) begin
          if (idx == LAST_IDX) begin
            state_nxt = ST_BODY;
            idx_nxt   = '0;
          end else begin
            idx_nxt = idx + 1'b1;
          end
        end
      end
      ST_BODY: begin
        if (hs) begin
          if (idx != LAST_IDX) begin
            idx_nxt = idx + 1'b1;
          end else if (act_load) begin
            state_nxt = ST_CP;
            idx_nxt   = CP_START;
          end else begin
            state_nxt = ST_IDLE;
            idx_nxt   = '0;
          end
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        idx_nxt   = '0;
      end
    endcase
  end

  assign o_sample_re = act_re[idx*WORD_SIZE +: WORD_SIZE];
  assign o_sample_im = act_im[idx*WORD_SIZE +: WORD_SIZE];
  assign o_valid     = (state != ST_IDLE);
  assign o_sof       = (state == ST_CP) & (idx == CP_START);
  assign o_eof       = (state == ST_BODY) & (idx == LAST_IDX);
  assign o_overflow  = overflow;
  assign o_busy      = act_full | pend_full;

endmodule

// File: tb/tb_ofdm_cp_serializer.sv
// tb/tb_ofdm_cp_serializer.sv - directed self-checking bench for ofdm_cp_serializer
module tb_ofdm_cp_serializer;

  localparam int W  = 16;
  localparam int N  = 32;
  localparam int CP = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N*W-1:0] frame_re = '0;
  logic [N*W-1:0] frame_im = '0;
  logic           frame_valid = 1'b0;
  logic           ready = 1'b0;
  logic [W-1:0]   sample_re, sample_im;
  logic           valid, sof, eof, overflow, busy;

  always #5 clk = ~clk;

  ofdm_cp_serializer #(.WORD_SIZE(W), .N_POINTS(N), .CP_LEN(CP)) dut (
    .i_clk(clk), .i_rst(rst_n),
    .i_frame_re(frame_re), .i_frame_im(frame_im), .i_frame_valid(frame_valid),
    .o_sample_re(sample_re), .o_sample_im(sample_im), .o_valid(valid),
    .i_ready(ready), .o_sof(sof), .o_eof(eof),
    .o_overflow(overflow), .o_busy(busy)
  );

  typedef struct {
    int ready_pat;
    int n_cycles;
    int p0_cyc; int p0_base;
    int p1_cyc; int p1_base;
    int p2_cyc; int p2_base;
    int nframes; int f0; int f1;
    int sof0; int sof1;
    int ovf;
  } vec_t;

  vec_t vecs[5];
  vec_t v_after_reset;
  int   checks = 0;
  int   errors = 0;
  logic [33:0] got_q[$];
  int          sof_cyc[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic load_frame(input int base);
    for (int k = 0; k < N; k++) begin
      frame_re[k*W +: W] = W'(base + k);
      frame_im[k*W +: W] = W'(-(base + k));
    end
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    frame_valid = 1'b0;
    ready       = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_outputs", {valid, sof, eof, overflow, busy, sample_re, sample_im}, '0);
    rst_n = 1'b1;
  endtask

  task automatic run_seq(input vec_t v);
    logic [34:0] held;
    logic        hold_pending;
    logic        rdy;
    logic [33:0] exp_q[$];
    int          bases[2];
    int          i;
    hold_pending = 1'b0;
    held         = '0;
    got_q.delete();
    sof_cyc.delete();
    for (int c = 0; c < v.n_cycles; c++) begin
      @(negedge clk);
      if (hold_pending)
        check($sformatf("hold_c%0d", c), {valid, sample_re, sample_im, sof, eof}, held);
      if (c == 0) check("idle_before_pulse", valid, 1'b0);
      rdy         = v.ready_pat[c % 4];
      ready       = rdy;
      frame_valid = 1'b0;
      if (c == v.p0_cyc) begin load_frame(v.p0_base); frame_valid = 1'b1; end
      else if (c == v.p1_cyc) begin load_frame(v.p1_base); frame_valid = 1'b1; end
      else if (c == v.p2_cyc) begin load_frame(v.p2_base); frame_valid = 1'b1; end
      if (valid && rdy) begin
        got_q.push_back({sample_re, sample_im, sof, eof});
        if (sof) sof_cyc.push_back(c);
      end
      hold_pending = valid && !rdy;
      held         = {valid, sample_re, sample_im, sof, eof};
    end
    check("overflow_end", overflow, v.ovf[0]);
    check("valid_end", valid, 1'b0);
    check("busy_end", busy, 1'b0);
    frame_valid = 1'b0;
    ready       = 1'b0;

    bases[0] = v.f0;
    bases[1] = v.f1;
    for (int f = 0; f < v.nframes; f++) begin
      for (int s = 0; s < N + CP; s++) begin
        i = (s < CP) ? (N - CP + s) : (s - CP);
        exp_q.push_back({W'(bases[f] + i), W'(-(bases[f] + i)), (s == 0), (s == N + CP - 1)});
      end
    end
    check("sample_count", got_q.size(), exp_q.size());
    for (int s = 0; s < exp_q.size() && s < got_q.size(); s++)
      check($sformatf("sample%0d", s), got_q[s], exp_q[s]);
    check("sof_count", sof_cyc.size(), v.nframes);
    if (sof_cyc.size() > 0) check("sof0_cycle", sof_cyc[0], v.sof0);
    if (sof_cyc.size() > 1) check("sof1_cycle", sof_cyc[1], v.sof1);
  endtask

  initial begin
    logic found;
    // ready_pat, cycles, pulses {cyc,base}x3, nframes, f0, f1, sof0, sof1, ovf
    vecs[0] = '{15,  50, 0, 0, -1,   0, -1,   0, 1, 0,   0, 1, -1, 0};
    vecs[1] = '{ 9, 100, 0, 0, -1,   0, -1,   0, 1, 0,   0, 3, -1, 0};
    vecs[2] = '{15,  90, 0, 0, 10, 100, -1,   0, 2, 0, 100, 1, 41, 0};
    vecs[3] = '{15,  90, 0, 0,  2, 100,  4, 200, 2, 0, 100, 1, 41, 1};
    vecs[4] = '{15,  90, 0, 0, 40,  50, -1,   0, 2, 0,  50, 1, 41, 0};
    v_after_reset = '{15, 50, 0, 300, -1, 0, -1, 0, 1, 300, 0, 1, -1, 0};

    for (int t = 0; t < 5; t++) begin
      do_reset();
      run_seq(vecs[t]);
    end

    do_reset();
    @(negedge clk);
    ready = 1'b1;
    load_frame(0);
    frame_valid = 1'b1;
    @(negedge clk);
    frame_valid = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 60 && !found; c++) begin
      if (valid && !sof && sample_re == W'(10)) found = 1'b1;
      else @(negedge clk);
    end
    check("reached_body10", found, 1'b1);
    #2 rst_n = 1'b0;
    #1 check("async_reset_outputs", {valid, sof, eof, overflow, busy, sample_re, sample_im}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check($sformatf("idle_after_reset%0d", c), valid, 1'b0);
    end
    run_seq(v_after_reset);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/ofdm_cp_serializer.md
Name: ofdm_cp_serializer

Overview:
- Sits directly downstream of the 32-point OFDM IFFT/FFT stage.
- Captures the 32 parallel complex output samples on the stage's cycle-done pulse.
- Prepends a cyclic prefix and streams one complex sample per handshake over a valid/ready interface toward the DAC/transmit path.
- Holds one pending frame so back-to-back symbols stream without gaps; flags any frame dropped on overflow.

Parameters:
WORD_SIZE, 16, bit width of each real/imag sample (two's complement)
N_POINTS, 32, samples per OFDM symbol (power of two)
CP_LEN, 8, cyclic prefix length; legal range 1..N_POINTS-1

Ports:
i_clk  input  1  system clock
i_rst  input  1  asynchronous active-low reset
i_frame_re  input  N_POINTS*WORD_SIZE  real parts; sample k at bits [k*WORD_SIZE +: WORD_SIZE]
i_frame_im  input  N_POINTS*WORD_SIZE  imag parts, same packing
i_frame_valid  input  1  one-cycle pulse; frame bus valid this cycle (driven by o_FFT32_cycle_done)
o_sample_re  output  WORD_SIZE  current output sample, real
o_sample_im  output  WORD_SIZE  current output sample, imag
o_valid  output  1  o_sample_* valid
i_ready  input  1  downstream accepts sample when o_valid & i_ready
o_sof  output  1  high with first CP sample of a symbol
o_eof  output  1  high with last body sample (index N_POINTS-1)
o_overflow  output  1  sticky; a frame was dropped
o_busy  output  1  active or pending buffer occupied

Behaviour:
- Reset (i_rst low, async): state IDLE, index 0, both buffers empty and zeroed. o_valid, o_sof, o_eof, o_overflow, o_busy = 0; o_sample_* = 0. Reset mid-symbol abandons the symbol; no partial continuation.
- Storage: an active buffer and a pending buffer, each N_POINTS x 2 x WORD_SIZE. Each has a full flag.
- FSM states:
  - IDLE: o_valid = 0.
  - CP: index runs N_POINTS-CP_LEN .. N_POINTS-1.
  - BODY: index runs 0 .. N_POINTS-1.
- Outputs:
  - o_sample_* = active[index], selected by a mux from registered state only; no input-to-output combinational path.
  - o_valid = (state != IDLE).
  - o_sof = CP & index == N_POINTS-CP_LEN.
  - o_eof = BODY & index == N_POINTS-1.
- Handshake: state and index advance only on o_valid & i_ready. With i_ready low, all outputs hold stable.
- Latency: a frame captured in IDLE on edge t gives o_valid = 1 with the first CP sample from edge t+1.
- Transitions:
  - CP last index + handshake -> BODY, index 0.
  - BODY last index + handshake -> if pending full or i_frame_valid this cycle: CP at N_POINTS-CP_LEN with no bubble; else IDLE.
- Capture rules on i_frame_valid:
  - Active free (IDLE, or BODY last-sample handshake this cycle) and pending empty: load into active.
  - Active busy and pending empty: load into pending.
  - Active freeing this cycle and pending full: pending -> active, new frame -> pending; no drop.
  - Active busy and pending full: frame dropped; o_overflow set next edge, cleared only by reset. Buffers unchanged.
- Pending never bypasses active; output symbol order always equals capture order.
- Data is passed bit-exact; no arithmetic, scaling or saturation.
- Index width: clog2(N_POINTS); wrap-around never occurs because the FSM resets the index explicitly.
- o_busy = active full | pending full.

Decomposition:
- Shared package: OFDM constants (WORD_SIZE, N_POINTS, CP_LEN defaults, index width via clog2) and the FSM state enum, reused by the future receive-side CP remover.
- One natural sub-module: ofdm_frame_buffer (one N_POINTS complex register bank with load, index read port, and full flag), instantiated twice for active and pending.

Test Plan:
1. Frame re[k] = k, im[k] = -k, i_ready = 1 -> o_valid rises 1 cycle after the pulse; 40 samples re = 24..31,0..31; o_sof on first (re = 24); o_eof on last (re = 31); o_valid low afterwards.
2. Same frame, i_ready toggled 1,0,0,1 repeating -> identical 40-sample sequence; outputs hold during i_ready = 0; no sample duplicated or lost.
3. Frame A (re = k) then frame B (re = 100+k) pulsed 10 cycles later, i_ready = 1 -> 80 contiguous valid samples (A then B); o_sof at cycles 1 and 41; o_overflow = 0.
4. Three pulses within 5 cycles (re = k, 100+k, 200+k) -> first two frames streamed; third dropped; o_overflow = 1 and sticky.
5. Frame pulse coincident with BODY index 31 handshake, pending empty -> next cycle o_sof = 1 with new frame's re[24]; no idle cycle.
6. i_rst low during BODY index 10, then released -> all outputs 0 immediately (async); o_valid stays 0 until the next pulse; new frame streams from its CP start.
